// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice. Purely combinational: every internal carry
// is expanded directly from the slice carry-in, so no carry ripples inside
// the slice.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms, lookahead carries and sum bits
    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0]
             | (p[0] & c[0]);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & c[0]);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);

        s    = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_16bit_ripple.sv
// 16-bit unsigned adder: four 4-bit lookahead slices with the carry rippling
// between slices, followed by a single output register (1-cycle latency).
module cla_16bit_ripple (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        carry
);

    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 16 / SLICE_W;

    // chain[i] is the carry into slice i; chain[NUM_SLICES] is the final carry
    logic [NUM_SLICES:0] chain;
    logic [15:0]         sum_comb;

    assign chain[0] = cin;

    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        cla_4bit u_slice (
            .a    (a[i*SLICE_W +: SLICE_W]),
            .b    (b[i*SLICE_W +: SLICE_W]),
            .cin  (chain[i]),
            .s    (sum_comb[i*SLICE_W +: SLICE_W]),
            .cout (chain[i+1])
        );
    end

    // Register the 17-bit result; reset clears it without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= 16'h0000;
            carry <= 1'b0;
        end else begin
            sum   <= sum_comb;
            carry <= chain[NUM_SLICES];
        end
    end

endmodule

// File: tb/tb_cla_16bit_ripple.sv
// Self-checking bench for cla_16bit_ripple: directed cases plus a random
// regression against plain 17-bit arithmetic, with a mid-stream reset pulse.
module tb_cla_16bit_ripple;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        carry;

    int checks;
    int errors;

    cla_16bit_ripple dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive operands at the falling edge, optionally pulse reset before the
    // next rising edge, then check the registered result just after that edge.
    task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input bit pulse_rst);
        logic [16:0] exp;
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        if (pulse_rst) begin
            #1 rst_n = 1'b0;
            #1 chk({tag, "_rst"}, {carry, sum}, 17'h0);
            #1 rst_n = 1'b1;
        end
        exp = {1'b0, va} + {1'b0, vb} + {16'h0, vc};
        @(posedge clk);
        #1 chk(tag, {carry, sum}, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = 16'($urandom);
        b      = 16'($urandom);
        cin    = 1'($urandom);

        // Outputs must be clear before any clock edge has occurred
        #2 chk("reset_no_edge", {carry, sum}, 17'h0);

        @(negedge clk);
        chk("reset_held", {carry, sum}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("rel_first",   16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        apply("a5_b9",       16'd5,    16'd9,    1'b0, 1'b0);
        apply("a111_b41",    16'd111,  16'd41,   1'b0, 1'b0);
        apply("a15_b9",      16'd15,   16'd9,    1'b0, 1'b0);
        apply("a2_b3",       16'd2,    16'd3,    1'b0, 1'b0);
        apply("ffff_cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0);
        apply("8000_8000",   16'h8000, 16'h8000, 1'b0, 1'b0);
        apply("ffff_0001",   16'hFFFF, 16'h0001, 1'b0, 1'b0);
        apply("full_scale",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        apply("zero",        16'h0000, 16'h0000, 1'b0, 1'b0);
        apply("zero_cin",    16'h0000, 16'h0000, 1'b1, 1'b0);
        apply("slice_edges", 16'h0FFF, 16'h0001, 1'b0, 1'b0);
        apply("alt_bits",    16'hAAAA, 16'h5555, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            apply("random", 16'($urandom), 16'($urandom), 1'($urandom), i == 150);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
